// File: rtl/dispatch_controller.sv
// Dispatch controller: pops the relief-request head, assigns it to the lowest free
// rescue team, loads that team's mission countdown and reports the dispatch.
module dispatch_controller #(
  parameter int NUM_TEAMS  = 4,
  parameter int BASE_TIME  = 10,
  parameter int PRI_STEP   = 4,
  parameter int EVAC_EXTRA = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 dispatch_en,
  input  logic                 req_valid,
  input  logic [7:0]           req_zone,
  input  logic [1:0]           req_priority,
  input  logic                 req_is_evac,
  output logic                 serve,
  output logic                 dispatch_valid,
  output logic [2:0]           dispatch_team,
  output logic [7:0]           dispatch_zone,
  output logic [7:0]           dispatch_time,
  output logic [NUM_TEAMS-1:0] team_busy,
  output logic                 all_busy,
  output logic [15:0]          dispatch_count
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_SETTLE} state_t;

  localparam logic [9:0] BASE10 = 10'(BASE_TIME);
  localparam logic [9:0] STEP10 = 10'(PRI_STEP);
  localparam logic [9:0] EVAC10 = 10'(EVAC_EXTRA);

  state_t      r_state;
  state_t      w_next_state;
  logic [7:0]  r_timer [NUM_TEAMS];
  logic [2:0]  r_lat_team;
  logic [7:0]  r_lat_zone;
  logic [7:0]  r_lat_time;
  logic [2:0]  r_out_team;
  logic [7:0]  r_out_zone;
  logic [7:0]  r_out_time;
  logic [15:0] r_count;
  logic        w_start;
  logic        w_fire;
  logic [2:0]  w_sel;
  logic [9:0]  w_sum;
  logic [7:0]  w_dur;

  // Mission duration: 10-bit sum, saturated to 8 bits, never zero.
  always_comb begin
    w_sum = BASE10 + STEP10 * {8'd0, req_priority} + (req_is_evac ? EVAC10 : 10'd0);
    if (w_sum > 10'd255)
      w_dur = 8'd255;
    else if (w_sum == 10'd0)
      w_dur = 8'd1;
    else
      w_dur = w_sum[7:0];
  end

  always_comb begin
    team_busy = '0;
    w_sel     = 3'd0;
    for (int i = 0; i < NUM_TEAMS; i++)
      team_busy[i] = (r_timer[i] != 8'd0);
    for (int i = NUM_TEAMS - 1; i >= 0; i--)
      if (!team_busy[i]) w_sel = 3'(i);
  end

  assign all_busy = &team_busy;

  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    w_start      = 1'b0;
    w_fire       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (dispatch_en && req_valid && !all_busy) begin
          w_start      = 1'b1;
          w_next_state = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_fire       = req_valid;
        w_next_state = req_valid ? S_SETTLE : S_IDLE;
      end
      S_SETTLE: w_next_state = S_IDLE;
      default:  w_next_state = S_IDLE;
    endcase
  end

  assign serve          = w_fire;
  assign dispatch_valid = w_fire;
  assign dispatch_team  = w_fire ? r_lat_team : r_out_team;
  assign dispatch_zone  = w_fire ? r_lat_zone : r_out_zone;
  assign dispatch_time  = w_fire ? r_lat_time : r_out_time;
  assign dispatch_count = r_count;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_lat_team <= 3'd0;
      r_lat_zone <= 8'd0;
      r_lat_time <= 8'd0;
      r_out_team <= 3'd0;
      r_out_zone <= 8'd0;
      r_out_time <= 8'd0;
      r_count    <= 16'd0;
    end else begin
      r_state <= w_next_state;
      if (w_start) begin
        r_lat_team <= w_sel;
        r_lat_zone <= req_zone;
        r_lat_time <= w_dur;
      end
      if (w_fire) begin
        r_out_team <= r_lat_team;
        r_out_zone <= r_lat_zone;
        r_out_time <= r_lat_time;
        r_count    <= r_count + 16'd1;
      end
    end
  end

  // NOTE: the timer array is reset explicitly because busy status must clear on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_TEAMS; i++)
        r_timer[i] <= 8'd0;
    end else begin
      for (int i = 0; i < NUM_TEAMS; i++) begin
        if (w_fire && (r_lat_team == 3'(i)))
          r_timer[i] <= r_lat_time;
        else if (r_timer[i] != 8'd0)
          r_timer[i] <= r_timer[i] - 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_dispatch_controller.sv
// Self-checking bench for dispatch_controller: vector table, directed multi-cycle
// sequences and a randomized run against a transaction-level reference model.
module tb_dispatch_controller;

  localparam int NT    = 4;
  localparam int BASE  = 10;
  localparam int STEP  = 4;
  localparam int EXTRA = 8;

  logic          clk;
  logic          rst_n;
  logic          dispatch_en;
  logic          req_valid;
  logic [7:0]    req_zone;
  logic [1:0]    req_priority;
  logic          req_is_evac;
  logic          serve;
  logic          dispatch_valid;
  logic [2:0]    dispatch_team;
  logic [7:0]    dispatch_zone;
  logic [7:0]    dispatch_time;
  logic [NT-1:0] team_busy;
  logic          all_busy;
  logic [15:0]   dispatch_count;

  int n_checks = 0;
  int n_fail   = 0;

  dispatch_controller #(
    .NUM_TEAMS(NT), .BASE_TIME(BASE), .PRI_STEP(STEP), .EVAC_EXTRA(EXTRA)
  ) dut (
    .clk(clk), .rst_n(rst_n), .dispatch_en(dispatch_en), .req_valid(req_valid),
    .req_zone(req_zone), .req_priority(req_priority), .req_is_evac(req_is_evac),
    .serve(serve), .dispatch_valid(dispatch_valid), .dispatch_team(dispatch_team),
    .dispatch_zone(dispatch_zone), .dispatch_time(dispatch_time),
    .team_busy(team_busy), .all_busy(all_busy), .dispatch_count(dispatch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic [7:0] zone;
    logic [1:0] pri;
    logic       evac;
    logic       exp_serve;
    logic [7:0] exp_time;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n        = 1'b0;
    dispatch_en  = 1'b0;
    req_valid    = 1'b0;
    req_zone     = 8'd0;
    req_priority = 2'd0;
    req_is_evac  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic drive(input logic en, input logic v, input logic [7:0] z,
                       input logic [1:0] p, input logic e);
    dispatch_en  = en;
    req_valid    = v;
    req_zone     = z;
    req_priority = p;
    req_is_evac  = e;
  endtask

  function automatic int model_dur(input int p, input bit e);
    int s;
    s = (BASE + STEP * p + (e ? EXTRA : 0)) % 1024;
    if (s > 255) s = 255;
    if (s == 0) s = 1;
    return s;
  endfunction

  // Reference model: per-team remaining mission cycles plus the pending award.
  int m_rem[NT];
  bit m_pending;
  bit m_cool;
  int m_pteam, m_pzone, m_ptime;
  int m_lteam, m_lzone, m_ltime;
  int m_count;

  initial begin
    int sn[8];
    int st[8];
    int k;
    int bad;

    vecs[0] = '{1'b1, 8'h21, 2'd2, 1'b0, 1'b1, 8'd18};
    vecs[1] = '{1'b1, 8'h05, 2'd3, 1'b1, 1'b1, 8'd30};
    vecs[2] = '{1'b1, 8'hAA, 2'd0, 1'b0, 1'b1, 8'd10};
    vecs[3] = '{1'b1, 8'h7F, 2'd1, 1'b1, 1'b1, 8'd22};
    vecs[4] = '{1'b1, 8'hFF, 2'd3, 1'b0, 1'b1, 8'd22};
    vecs[5] = '{1'b0, 8'h33, 2'd2, 1'b1, 1'b0, 8'd0};

    // Reset state
    do_reset();
    @(negedge clk);
    check("reset_serve", serve, 0);
    check("reset_dvalid", dispatch_valid, 0);
    check("reset_team", dispatch_team, 0);
    check("reset_zone", dispatch_zone, 0);
    check("reset_time", dispatch_time, 0);
    check("reset_busy", team_busy, 0);
    check("reset_all_busy", all_busy, 0);
    check("reset_count", dispatch_count, 0);

    // Single-request vectors, each from a fresh reset
    foreach (vecs[i]) begin
      do_reset();
      drive(vecs[i].en, 1'b1, vecs[i].zone, vecs[i].pri, vecs[i].evac);
      @(negedge clk);
      check("vec_idle_serve", serve, 0);
      next_cycle();
      @(negedge clk);
      check("vec_serve", serve, vecs[i].exp_serve);
      check("vec_dvalid", dispatch_valid, vecs[i].exp_serve);
      if (vecs[i].exp_serve) begin
        check("vec_team", dispatch_team, 0);
        check("vec_zone", dispatch_zone, vecs[i].zone);
        check("vec_time", dispatch_time, vecs[i].exp_time);
      end
      next_cycle();
      req_valid = 1'b0;
      @(negedge clk);
      check("vec_busy_after", team_busy, {3'b000, vecs[i].exp_serve});
      check("vec_count_after", dispatch_count, {15'd0, vecs[i].exp_serve});
      check("vec_fields_hold", dispatch_zone, vecs[i].exp_serve ? vecs[i].zone : 8'd0);
    end

    // Continuous requests: teams 0..3 every 3 cycles, then stall until team 0 frees
    do_reset();
    drive(1'b1, 1'b1, 8'h10, 2'd3, 1'b1);
    k = 0;
    for (int n = 0; n <= 34; n++) begin
      @(negedge clk);
      if (serve && k < 8) begin
        sn[k] = n;
        st[k] = dispatch_team;
        k++;
      end
      if (n == 12) check("fill_all_busy_12", all_busy, 1);
      if (n == 31) check("fill_all_busy_31", all_busy, 1);
      if (n == 32) check("fill_all_busy_32", all_busy, 0);
      next_cycle();
    end
    check("fill_serve_total", k, 5);
    for (int i = 0; i < 5; i++) begin
      check("fill_serve_cycle", sn[i], (i < 4) ? 1 + 3 * i : 33);
      check("fill_serve_team", st[i], (i < 4) ? i : 0);
    end

    // Abort: req_valid drops during ISSUE, FSM returns straight to IDLE
    do_reset();
    drive(1'b1, 1'b1, 8'h44, 2'd1, 1'b0);
    @(negedge clk);
    next_cycle();
    req_valid = 1'b0;
    @(negedge clk);
    check("abort_serve", serve, 0);
    check("abort_dvalid", dispatch_valid, 0);
    next_cycle();
    req_valid = 1'b1;
    @(negedge clk);
    check("abort_count", dispatch_count, 0);
    check("abort_busy", team_busy, 0);
    check("abort_serve_idle", serve, 0);
    next_cycle();
    @(negedge clk);
    check("abort_redispatch", serve, 1);
    check("abort_redispatch_team", dispatch_team, 0);

    // Pause: dispatch_en low keeps timers running but blocks dispatch
    do_reset();
    bad = 0;
    for (int n = 0; n <= 20; n++) begin
      drive(!(n >= 2 && n <= 11), 1'b1, 8'h21, 2'd2, 1'b0);
      @(negedge clk);
      if (n == 1) check("pause_first_serve", serve, 1);
      if (n >= 2 && n <= 12 && serve) bad++;
      if (n == 11) check("pause_team0_busy", team_busy[0], 1);
      if (n == 13) begin
        check("pause_resume_serve", serve, 1);
        check("pause_resume_team", dispatch_team, 1);
      end
      if (n == 19) check("team0_busy_last", team_busy[0], 1);
      if (n == 20) check("team0_free", team_busy[0], 0);
      next_cycle();
    end
    check("pause_no_serve", bad, 0);

    // Asynchronous reset in the middle of ISSUE with busy teams
    do_reset();
    drive(1'b1, 1'b1, 8'h66, 2'd1, 1'b1);
    repeat (4) next_cycle();
    check("pre_rst_serve", serve, 1);
    check("pre_rst_busy", team_busy, 4'b0001);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_serve", serve, 0);
    check("arst_dvalid", dispatch_valid, 0);
    check("arst_busy", team_busy, 0);
    check("arst_all_busy", all_busy, 0);
    check("arst_count", dispatch_count, 0);
    check("arst_zone", dispatch_zone, 0);
    check("arst_time", dispatch_time, 0);

    // Randomized run against the reference model
    do_reset();
    for (int i = 0; i < NT; i++) m_rem[i] = 0;
    m_pending = 0; m_cool = 0;
    m_pteam = 0; m_pzone = 0; m_ptime = 0;
    m_lteam = 0; m_lzone = 0; m_ltime = 0;
    m_count = 0;
    for (int c = 0; c < 800; c++) begin
      int busy_vec;
      int free_team;
      bit fire;
      int load_team;
      drive($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 7, 8'($urandom),
            2'($urandom), 1'($urandom));
      @(negedge clk);
      fire = m_pending && req_valid;
      busy_vec = 0;
      for (int i = 0; i < NT; i++) if (m_rem[i] != 0) busy_vec |= (1 << i);
      check("rnd_serve", serve, fire);
      check("rnd_dvalid", dispatch_valid, fire);
      check("rnd_team", dispatch_team, fire ? m_pteam : m_lteam);
      check("rnd_zone", dispatch_zone, fire ? m_pzone : m_lzone);
      check("rnd_time", dispatch_time, fire ? m_ptime : m_ltime);
      check("rnd_busy", team_busy, busy_vec);
      check("rnd_all_busy", all_busy, busy_vec == (1 << NT) - 1);
      check("rnd_count", dispatch_count, m_count);
      @(posedge clk);
      free_team = -1;
      for (int i = NT - 1; i >= 0; i--) if (m_rem[i] == 0) free_team = i;
      load_team = fire ? m_pteam : -1;
      for (int i = 0; i < NT; i++)
        if (i == load_team) m_rem[i] = m_ptime;
        else if (m_rem[i] > 0) m_rem[i]--;
      if (m_pending) begin
        if (fire) begin
          m_count = (m_count + 1) % 65536;
          m_lteam = m_pteam; m_lzone = m_pzone; m_ltime = m_ptime;
          m_cool  = 1;
        end
        m_pending = 0;
      end else if (m_cool) begin
        m_cool = 0;
      end else if (dispatch_en && req_valid && free_team >= 0) begin
        m_pending = 1;
        m_pteam   = free_team;
        m_pzone   = req_zone;
        m_ptime   = model_dur(req_priority, req_is_evac);
      end
      #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
